class_score_argmax: RTL and testbench
=====================================

Name: class_score_argmax

Overview:
- Streaming bias-add and argmax stage for the classifier back end.
- Sits after the systolic fetcher. Accepts the raw class scores of each row one score per cycle and adds a signed per-class bias with saturation.
- Tracks the running maximum and emits one result per row: class index, one-hot and winning score, over a valid/ready handshake.
- Generalised over class count, row count and widths. Has back-pressure, tie rules and batch sequencing.

Parameters:
- DATA_WIDTH, 16, bias element width (signed).
- ACC_WIDTH, 32, score width (signed). Must be >= DATA_WIDTH.
- NUM_CLASSES, 10, classes per row. Must be >= 2.
- NUM_ROWS, 1, rows per batch. Must be >= 1.
- IDX_WIDTH, $clog2(NUM_CLASSES), class index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a batch.
- bias  in  NUM_CLASSES*DATA_WIDTH  flattened signed biases, class 0 in the LSBs. Must be stable while busy.
- in_valid  in  1  score valid.
- in_ready  out  1  block accepts a score.
- in_data  in  ACC_WIDTH  signed score, classes in order 0..NUM_CLASSES-1.
- out_valid  out  1  row result valid.
- out_ready  in  1  downstream accepts the result.
- out_class  out  IDX_WIDTH  winning class index.
- out_onehot  out  NUM_CLASSES  one-hot of out_class.
- out_score  out  ACC_WIDTH  winning biased score.
- busy  out  1  high from the start-accept cycle to the done cycle.
- done  out  1  one-cycle pulse after the last row's result is taken.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_class=0, out_onehot=0, out_score=0, busy=0, done=0.
  - Reset clears the state to IDLE and clears the counters.
  - Reset mid-operation abandons the batch with no result or done pulse.
- Counters:
  - cls_cnt runs 0..NUM_CLASSES-1.
  - row_cnt runs 0..NUM_ROWS-1.
- FSM states: IDLE, ACCUM, EMIT, DONE.
- IDLE:
  - start=1 moves to ACCUM, clears both counters and sets busy.
  - start is ignored in every other state.
- ACCUM:
  - in_ready=1. A transfer occurs when in_valid and in_ready are both high.
  - Per transfer: s = sat(in_data + sign_extend(bias[cls_cnt])).
  - sat clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Overflow is detected from operand signs.
  - cls_cnt=0: max is loaded unconditionally with s, idx=0.
  - Otherwise max/idx update only if s > max (strict compare). Ties keep the lower index.
  - On the transfer with cls_cnt=NUM_CLASSES-1, the last score is included in the compare. The final values are registered to out_*, and the state moves to EMIT.
  - Idle cycles (in_valid=0) stall without altering any state.
- EMIT:
  - out_valid=1 and in_ready=0. out_* are held stable until out_ready=1.
  - out_valid rises in the cycle after the last score is accepted, i.e. 1-cycle latency.
  - On handshake, out_valid drops next cycle.
  - If row_cnt<NUM_ROWS-1: increment row_cnt, clear cls_cnt, return to ACCUM.
  - Otherwise go to DONE.
  - If out_ready is already high on entry, the handshake completes in the first EMIT cycle.
- DONE:
  - done=1 for exactly one cycle. busy drops and the state returns to IDLE.
  - out_class, out_onehot and out_score keep the last row's values until the next start or reset.
- Ordering: a start arriving in the DONE cycle is ignored. A start in the following cycle is accepted.
- Widths: bias is sign-extended to ACC_WIDTH. The comparator and adder are ACC_WIDTH-bit signed. out_onehot = 1 << out_class.

Decomposition:
- Package class_score_pkg holds:
  - the state enum (IDLE/ACCUM/EMIT/DONE);
  - localparam helpers for index width;
  - a function sat_add_s(a, b) parametrised on width.
- One sub-module, score_sat_add: a combinational signed saturating adder (ACC_WIDTH + sign-extended DATA_WIDTH). Reused elsewhere by the bias-add path.
- The FSM, counters and max tracking live in the top module.

Test Plan:
- Single row, NUM_CLASSES=10, bias all 0, scores 5,-3,9,2,9,0,1,1,-8,4 -> out_class=2, out_onehot=10'b0000000100, out_score=9. Tie at class 4 loses. out_valid rises the cycle after the 10th score.
- Bias effect: scores all 100, bias[7]=+1, others 0 -> out_class=7, out_score=101.
- Saturation (ACC_WIDTH=32): score[3]=0x7FFFFFF0 with bias[3]=+0x7FFF, score[5]=0x7FFFFFFF with bias 0 -> s3 clamps to 0x7FFFFFFF, tying class 5; out_class=3.
- Negative floor: all scores 0x80000000, all biases -1 -> every sum clamps to min, out_class=0, out_score=0x80000000.
- Back-pressure and batch, NUM_ROWS=3:
  - Random in_valid gaps; out_ready low for 5 cycles on row 1.
  - Required: out_* stable throughout the stall, in_ready=0 during EMIT, three results in row order.
  - done pulses once, one cycle after the third handshake; busy falls with it.
- Reset mid-row after 4 scores, then a new start and a full row of scores 0..9 -> no stale result, out_class=9, done pulses once.

Source files
------------

// File: rtl/class_score_pkg.sv
// Shared types and helpers for the classifier back-end score path.
package class_score_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

  // Index width that stays legal (>= 1 bit) for a count of one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] sat_add_s(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int              width);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    // Operands are in range for width, so overflow shows up as a sign flip at bit width-1.
    if (!a[width-1] && !b[width-1] && sum[width-1])
      return max_v;
    if (a[width-1] && b[width-1] && !sum[width-1])
      return min_v;
    return sum;
  endfunction

endpackage

// File: rtl/score_sat_add.sv
// Combinational signed saturating adder: wide score plus sign-extended narrow bias.
module score_sat_add #(
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0]  a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  sum
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_VAL = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_VAL = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] b_ext;
  logic signed [ACC_WIDTH-1:0] raw;
  logic                        pos_ovf;
  logic                        neg_ovf;

  assign b_ext = ACC_WIDTH'(b);
  assign raw   = a + b_ext;

  // Same-sign operands producing an opposite-sign result is the only overflow case.
  assign pos_ovf = !a[ACC_WIDTH-1] && !b_ext[ACC_WIDTH-1] &&  raw[ACC_WIDTH-1];
  assign neg_ovf =  a[ACC_WIDTH-1] &&  b_ext[ACC_WIDTH-1] && !raw[ACC_WIDTH-1];

  assign sum = pos_ovf ? MAX_VAL : (neg_ovf ? MIN_VAL : raw);

endmodule

// File: rtl/class_score_argmax.sv
// Streaming bias-add and argmax: one score per cycle in, one class result per row out.
module class_score_argmax
  import class_score_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int NUM_CLASSES = 10,
  parameter int NUM_ROWS    = 1,
  parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] bias,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [ACC_WIDTH-1:0]       in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IDX_WIDTH-1:0]              out_class,
  output logic [NUM_CLASSES-1:0]            out_onehot,
  output logic signed [ACC_WIDTH-1:0]       out_score,
  output logic                              busy,
  output logic                              done
);

  localparam int                   ROW_WIDTH = idx_width(NUM_ROWS);
  localparam logic [IDX_WIDTH-1:0] LAST_CLS  = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [ROW_WIDTH-1:0] LAST_ROW  = ROW_WIDTH'(NUM_ROWS - 1);

  state_t                      state;
  logic [IDX_WIDTH-1:0]        cls_cnt;
  logic [ROW_WIDTH-1:0]        row_cnt;
  logic [IDX_WIDTH-1:0]        cur_idx;
  logic signed [ACC_WIDTH-1:0] cur_max;
  logic signed [DATA_WIDTH-1:0] cls_bias;
  logic signed [ACC_WIDTH-1:0] biased;
  logic                        xfer;
  logic                        take_new;
  logic [IDX_WIDTH-1:0]        best_idx;
  logic signed [ACC_WIDTH-1:0] best_val;

  always_comb begin
    cls_bias = '0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (cls_cnt == IDX_WIDTH'(i))
        cls_bias = bias[i*DATA_WIDTH +: DATA_WIDTH];
  end

  score_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sat_add (
    .a  (in_data),
    .b  (cls_bias),
    .sum(biased)
  );

  assign xfer = in_valid && in_ready;

  // Strict greater-than keeps the lower index on ties; class 0 always seeds the max.
  always_comb begin
    take_new = (cls_cnt == '0) || (biased > cur_max);
    best_val = take_new ? biased  : cur_max;
    best_idx = take_new ? cls_cnt : cur_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cls_cnt    <= '0;
      row_cnt    <= '0;
      cur_idx    <= '0;
      cur_max    <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_class  <= '0;
      out_onehot <= '0;
      out_score  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCUM;
            cls_cnt    <= '0;
            row_cnt    <= '0;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
            out_class  <= '0;
            out_onehot <= '0;
            out_score  <= '0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            cur_max <= best_val;
            cur_idx <= best_idx;
            if (cls_cnt == LAST_CLS) begin
              out_class  <= best_idx;
              out_onehot <= NUM_CLASSES'(1) << best_idx;
              out_score  <= best_val;
              out_valid  <= 1'b1;
              in_ready   <= 1'b0;
              state      <= EMIT;
            end else begin
              cls_cnt <= cls_cnt + IDX_WIDTH'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row_cnt != LAST_ROW) begin
              row_cnt  <= row_cnt + ROW_WIDTH'(1);
              cls_cnt  <= '0;
              in_ready <= 1'b1;
              state    <= ACCUM;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_score_argmax.sv
// Randomised bench for class_score_argmax against a plain-arithmetic argmax model.
module tb_class_score_argmax;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int NC = 10;
  localparam int NR = 3;
  localparam int IW = $clog2(NC);
  localparam longint SMAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [NC*DW-1:0]     bias;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [AW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_class;
  logic [NC-1:0]        out_onehot;
  logic signed [AW-1:0] out_score;
  logic                 busy;
  logic                 done;

  int vectors     = 0;
  int miscompares = 0;
  int done_pulses = 0;

  logic signed [AW-1:0] sc_tab   [NR][NC];
  logic signed [DW-1:0] bias_tab [NC];

  logic [IW-1:0]        obs_cls   [NR];
  logic [NC-1:0]        obs_oh    [NR];
  logic signed [AW-1:0] obs_score [NR];
  bit obs_lat [NR];
  bit obs_to  [NR];
  bit obs_stable [NR];
  bit obs_irlow  [NR];
  bit obs_drop   [NR];
  bit obs_busy_start, obs_done1, obs_busy1, obs_done2, obs_busy2;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_bias
    assign bias[g*DW +: DW] = bias_tab[g];
  end

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  class_score_argmax #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .NUM_CLASSES(NC),
    .NUM_ROWS   (NR),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_onehot(out_onehot),
    .out_score (out_score),
    .busy      (busy),
    .done      (done)
  );

  // Reference: clamp the exact sum, then pick the first index holding the maximum.
  function automatic longint ref_sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic void ref_row(input int r, output int cls, output longint best);
    longint s;
    best = 0;
    cls  = 0;
    for (int c = 0; c < NC; c++) begin
      s = ref_sat(longint'(sc_tab[r][c]) + longint'(bias_tab[c]));
      if (c == 0 || s > best) begin
        best = s;
        cls  = c;
      end
    end
  endfunction

  task automatic fill_random_rows(input int first);
    for (int r = first; r < NR; r++)
      for (int c = 0; c < NC; c++)
        case ($urandom_range(0, 2))
          0:       sc_tab[r][c] = $urandom;
          1:       sc_tab[r][c] = int'($urandom_range(0, 6)) - 3;
          default: sc_tab[r][c] = 32'h7FFF_FF00 + $urandom_range(0, 255);
        endcase
  endtask

  task automatic fill_random_bias();
    for (int c = 0; c < NC; c++)
      bias_tab[c] = ($urandom_range(0, 1) == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 4)) - 2);
  endtask

  task automatic send_score(input logic signed [AW-1:0] v, input int gap_max);
    int guard;
    in_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_batch(input int gap_max, input int stall_row, input int stall_cycles,
                           input bit poke_done_start);
    int guard;
    done_pulses = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs_busy_start = busy;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) send_score(sc_tab[r][c], gap_max);
      obs_lat[r] = (out_valid === 1'b1);
      guard = 0;
      while (out_valid !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      obs_to[r]     = (out_valid !== 1'b1);
      obs_cls[r]    = out_class;
      obs_oh[r]     = out_onehot;
      obs_score[r]  = out_score;
      obs_stable[r] = 1'b1;
      obs_irlow[r]  = (in_ready === 1'b0);
      if (r == stall_row)
        repeat (stall_cycles) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || out_class !== obs_cls[r] || out_onehot !== obs_oh[r] ||
              out_score !== obs_score[r]) obs_stable[r] = 1'b0;
          if (in_ready !== 1'b0) obs_irlow[r] = 1'b0;
        end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready   = 1'b0;
      obs_drop[r] = (out_valid === 1'b0);
    end
    obs_done1 = done;
    obs_busy1 = busy;
    if (poke_done_start) start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    obs_done2 = done;
    obs_busy2 = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int c = 0; c < NC; c++) bias_tab[c] = '0;
    repeat (3) @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_class !== '0) begin miscompares++; $display("[TB] FAIL reset_out_class: got %0d expected 0", out_class); end
    vectors++; if (out_onehot !== '0) begin miscompares++; $display("[TB] FAIL reset_out_onehot: got %b expected 0", out_onehot); end
    vectors++; if (out_score !== '0) begin miscompares++; $display("[TB] FAIL reset_out_score: got %0d expected 0", out_score); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_rows_vs_model(input string tag);
    int     ecls;
    longint escore;
    logic [NC-1:0] eoh;
    for (int r = 0; r < NR; r++) begin
      ref_row(r, ecls, escore);
      eoh = '0;
      eoh[ecls] = 1'b1;
      vectors++; if (obs_to[r]) begin miscompares++; $display("[TB] FAIL %s_valid_timeout row%0d: out_valid never rose, required 1", tag, r); end
      vectors++; if (obs_cls[r] !== IW'(ecls)) begin miscompares++; $display("[TB] FAIL %s_class row%0d: got %0d expected %0d", tag, r, obs_cls[r], ecls); end
      vectors++; if (obs_oh[r] !== eoh) begin miscompares++; $display("[TB] FAIL %s_onehot row%0d: got %b expected %b", tag, r, obs_oh[r], eoh); end
      vectors++; if (obs_score[r] !== AW'(escore)) begin miscompares++; $display("[TB] FAIL %s_score row%0d: got %0d expected %0d", tag, r, obs_score[r], escore); end
    end
  endtask

  task automatic test_tie_rule();
    int dir [NC] = '{5, -3, 9, 2, 9, 0, 1, 1, -8, 4};
    for (int c = 0; c < NC; c++) begin bias_tab[c] = '0; sc_tab[0][c] = dir[c]; end
    fill_random_rows(1);
    run_batch(2, -1, 0, 1'b0);
    check_rows_vs_model("tie");
    vectors++; if (obs_cls[0] !== 4'd2 || obs_score[0] !== 32'sd9) begin miscompares++; $display("[TB] FAIL tie_directed: got class %0d score %0d expected class 2 score 9", obs_cls[0], obs_score[0]); end
    vectors++; if (obs_oh[0] !== 10'b0000000100) begin miscompares++; $display("[TB] FAIL tie_onehot_directed: got %b expected 0000000100", obs_oh[0]); end
    vectors++; if (!obs_lat[0]) begin miscompares++; $display("[TB] FAIL tie_latency: out_valid was 0 one cycle after last score, required 1"); end
  endtask

  task automatic test_bias_effect();
    for (int c = 0; c < NC; c++) begin bias_tab[c] = (c == 7) ? 16'sd1 : 16'sd0; sc_tab[0][c] = 32'sd100; end
    fill_random_rows(1);
    run_batch(1, -1, 0, 1'b0);
    check_rows_vs_model("bias");
    vectors++; if (obs_cls[0] !== 4'd7 || obs_score[0] !== 32'sd101) begin miscompares++; $display("[TB] FAIL bias_directed: got class %0d score %0d expected class 7 score 101", obs_cls[0], obs_score[0]); end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < NC; c++) begin bias_tab[c] = '0; sc_tab[0][c] = '0; end
    bias_tab[3]  = 16'sh7FFF;
    sc_tab[0][3] = 32'h7FFF_FFF0;
    sc_tab[0][5] = 32'h7FFF_FFFF;
    fill_random_rows(1);
    run_batch(0, -1, 0, 1'b0);
    check_rows_vs_model("sat");
    vectors++; if (obs_cls[0] !== 4'd3 || obs_score[0] !== 32'sh7FFF_FFFF) begin miscompares++; $display("[TB] FAIL sat_directed: got class %0d score %h expected class 3 score 7fffffff", obs_cls[0], obs_score[0]); end
  endtask

  task automatic test_negative_floor();
    for (int c = 0; c < NC; c++) begin bias_tab[c] = -16'sd1; sc_tab[0][c] = 32'h8000_0000; end
    fill_random_rows(1);
    run_batch(1, -1, 0, 1'b0);
    check_rows_vs_model("floor");
    vectors++; if (obs_cls[0] !== 4'd0 || obs_score[0] !== 32'sh8000_0000) begin miscompares++; $display("[TB] FAIL floor_directed: got class %0d score %h expected class 0 score 80000000", obs_cls[0], obs_score[0]); end
  endtask

  task automatic test_back_to_back();
    fill_random_bias();
    fill_random_rows(0);
    run_batch(3, 1, 5, 1'b1);
    check_rows_vs_model("bp");
    for (int r = 0; r < NR; r++) begin
      vectors++; if (!obs_stable[r] || !obs_irlow[r]) begin miscompares++; $display("[TB] FAIL bp_emit_hold row%0d: stable=%b in_ready_low=%b expected 1 1", r, obs_stable[r], obs_irlow[r]); end
      vectors++; if (!obs_drop[r] || !obs_lat[r]) begin miscompares++; $display("[TB] FAIL bp_valid_timing row%0d: dropped=%b latency_ok=%b expected 1 1", r, obs_drop[r], obs_lat[r]); end
    end
    vectors++; if (obs_busy_start !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_busy_start: got %b expected 1", obs_busy_start); end
    vectors++; if (obs_done1 !== 1'b1 || obs_busy1 !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_done_cycle: done=%b busy=%b expected 1 0", obs_done1, obs_busy1); end
    vectors++; if (obs_done2 !== 1'b0 || obs_busy2 !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_start_in_done: done=%b busy=%b expected 0 0", obs_done2, obs_busy2); end
    vectors++; if (done_pulses != 1) begin miscompares++; $display("[TB] FAIL bp_done_count: got %0d expected 1", done_pulses); end
    vectors++; if (out_class !== obs_cls[NR-1] || out_score !== obs_score[NR-1]) begin miscompares++; $display("[TB] FAIL bp_hold_after_done: got %0d/%0d expected %0d/%0d", out_class, out_score, obs_cls[NR-1], obs_score[NR-1]); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_start_after_done: busy=%b in_ready=%b expected 1 1", busy, in_ready); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_row();
    fill_random_bias();
    fill_random_rows(0);
    done_pulses = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) send_score(sc_tab[0][c], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done_pulses != 0) begin
      miscompares++; $display("[TB] FAIL midreset_abandon: busy=%b in_ready=%b out_valid=%b done_pulses=%0d expected 0 0 0 0", busy, in_ready, out_valid, done_pulses);
    end
    for (int c = 0; c < NC; c++) begin bias_tab[c] = '0; sc_tab[0][c] = c; end
    run_batch(1, -1, 0, 1'b0);
    check_rows_vs_model("midreset");
    vectors++; if (obs_cls[0] !== 4'd9 || obs_score[0] !== 32'sd9) begin miscompares++; $display("[TB] FAIL midreset_directed: got class %0d score %0d expected class 9 score 9", obs_cls[0], obs_score[0]); end
    vectors++; if (done_pulses != 1) begin miscompares++; $display("[TB] FAIL midreset_done_count: got %0d expected 1", done_pulses); end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_tie_rule();
    test_bias_effect();
    test_saturation();
    test_negative_floor();
    test_back_to_back();
    test_reset_mid_row();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
